// File: rtl/adder_tree_driver.sv
// Serial-to-parallel driver for an 8-lane adder tree. It loads eight operands
// into the tree lanes and keeps its own reference sum. After the tree latency
// it captures the tree result and flags any mismatch. The result is then held
// until the downstream side accepts it.
module adder_tree_driver #(
  parameter int WIDTH = 5,
  parameter int SUM_W = WIDTH + 3,
  parameter int LAT   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic [8*WIDTH-1:0] lane_out,
  input  logic [SUM_W-1:0]   tree_sum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SUM_W-1:0]   out_sum,
  output logic               out_err,
  output logic               err_sticky,
  output logic [15:0]        frame_cnt
);

  localparam int WCW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [2:0]              r_fill_cnt;
  logic [WCW-1:0]          r_wait_cnt;
  logic [SUM_W-1:0]        r_acc;
  logic [7:0][WIDTH-1:0]   r_lane;
  logic [SUM_W-1:0]        r_out_sum;
  logic                    r_out_err;
  logic                    r_err_sticky;
  logic [15:0]             r_frame_cnt;

  logic                    w_accept;
  logic                    w_last;
  logic                    w_capture;
  logic                    w_release;
  logic                    w_mismatch;

  assign w_accept   = in_valid && (r_state == FILL);
  assign w_last     = w_accept && (r_fill_cnt == 3'd7);
  assign w_capture  = (r_state == WAIT) && (r_wait_cnt == '0);
  assign w_release  = (r_state == HOLD) && out_ready;
  assign w_mismatch = (tree_sum != r_acc);

  assign in_ready   = (r_state == FILL);
  assign out_valid  = (r_state == HOLD);
  assign lane_out   = r_lane;
  assign out_sum    = r_out_sum;
  assign out_err    = r_out_err;
  assign err_sticky = r_err_sticky;
  assign frame_cnt  = r_frame_cnt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_next;
  end

  // Next-state logic: fill eight words, wait out tree latency, hold result
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      FILL:    if (w_last)    w_next = WAIT;
      WAIT:    if (w_capture) w_next = HOLD;
      HOLD:    if (w_release) w_next = FILL;
      default: w_next = FILL;
    endcase
  end

  // Operand loading: fill counter, lanes and reference accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_cnt <= '0;
      r_lane     <= '0;
      r_acc      <= '0;
    end else if (w_accept) begin
      // The counter wraps 7->0 on the last word, so it is already 0 for the next frame
      r_fill_cnt         <= r_fill_cnt + 3'd1;
      r_lane[r_fill_cnt] <= in_data;
      if (r_fill_cnt == 3'd0) r_acc <= SUM_W'(in_data);
      else                    r_acc <= r_acc + SUM_W'(in_data);
    end
  end

  // Tree latency countdown, loaded on the last accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     r_wait_cnt <= '0;
    else if (w_last)                             r_wait_cnt <= WCW'(LAT);
    else if (r_state == WAIT && !w_capture)      r_wait_cnt <= r_wait_cnt - WCW'(1);
  end

  // Result capture, error flags and completed-frame count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_sum    <= '0;
      r_out_err    <= 1'b0;
      r_err_sticky <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      if (w_capture) begin
        r_out_sum <= tree_sum;
        r_out_err <= w_mismatch;
        if (w_mismatch) r_err_sticky <= 1'b1;
      end
      if (w_release) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_adder_tree_driver.sv
// Directed bench for adder_tree_driver with a two-stage adder tree model.
module tb_adder_tree_driver;

  localparam int WIDTH = 5;
  localparam int SUM_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [8*WIDTH-1:0] lane_out;
  logic [SUM_W-1:0]   tree_sum;
  logic               out_valid;
  logic               out_ready;
  logic [SUM_W-1:0]   out_sum;
  logic               out_err;
  logic               err_sticky;
  logic [15:0]        frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [SUM_W-1:0] inj = '0;

  adder_tree_driver #(.WIDTH(WIDTH), .SUM_W(SUM_W), .LAT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .lane_out(lane_out), .tree_sum(tree_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_err(out_err), .err_sticky(err_sticky), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Adder tree model: two register stages, optional offset to force a mismatch
  logic [SUM_W-1:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    logic [SUM_W-1:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s = s + SUM_W'(lane_out[k*WIDTH +: WIDTH]);
    p1 <= s;
    p2 <= p1;
  end
  assign tree_sum = p2 + inj;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feed n words from a packed vector (word i at bits [i*5 +: 5]); gap inserts idle cycles
  task automatic feed(input logic [39:0] words, input int n, input bit gap, output int cycles);
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = words[i*WIDTH +: WIDTH];
      step();
      cycles++;
      in_valid = 1'b0;
      if (gap && i < n - 1) begin
        in_data = 5'h1F;
        step();
        cycles++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int t;
    t = 0;
    while (!out_valid && t < 20) begin
      step();
      t++;
    end
    chk(tag, 64'(out_valid), 64'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] seq18, all1f, all2, lanes18;
    int cyc;
    seq18   = {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    lanes18 = {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    all1f   = {8{5'h1F}};
    all2    = {8{5'd2}};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_in_ready",  64'(in_ready),   64'd1);
    chk("rst_out_valid", 64'(out_valid),  64'd0);
    chk("rst_lanes",     64'(lane_out),   64'd0);
    chk("rst_out_sum",   64'(out_sum),    64'd0);
    chk("rst_sticky",    64'(err_sticky), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt),  64'd0);

    // Basic frame: capture lands exactly three edges after the 8th accept
    feed(seq18, 8, 1'b0, cyc);
    chk("basic_e0_in_ready", 64'(in_ready),  64'd0);
    chk("basic_e0_valid",    64'(out_valid), 64'd0);
    step();
    chk("basic_e1_valid",    64'(out_valid), 64'd0);
    step();
    chk("basic_e2_valid",    64'(out_valid), 64'd0);
    step();
    chk("basic_e3_valid",    64'(out_valid), 64'd1);
    chk("basic_lanes",       64'(lane_out),  64'(lanes18));
    chk("basic_sum",         64'(out_sum),   64'h24);
    chk("basic_err",         64'(out_err),   64'd0);
    release_out();
    chk("basic_frame_cnt",   64'(frame_cnt), 64'd1);
    chk("basic_valid_drop",  64'(out_valid), 64'd0);
    chk("basic_in_ready",    64'(in_ready),  64'd1);

    // Max operands
    feed(all1f, 8, 1'b0, cyc);
    wait_out("max_valid");
    chk("max_sum", 64'(out_sum), 64'hF8);
    chk("max_err", 64'(out_err), 64'd0);
    release_out();
    chk("max_frame_cnt", 64'(frame_cnt), 64'd2);

    // Mismatch, then a clean frame: sticky flag survives
    inj = 8'd1;
    feed(seq18, 8, 1'b0, cyc);
    wait_out("mis_valid");
    chk("mis_sum",    64'(out_sum),    64'h25);
    chk("mis_err",    64'(out_err),    64'd1);
    chk("mis_sticky", 64'(err_sticky), 64'd1);
    release_out();
    inj = '0;
    feed(seq18, 8, 1'b0, cyc);
    wait_out("clean_valid");
    chk("clean_err",    64'(out_err),    64'd0);
    chk("clean_sticky", 64'(err_sticky), 64'd1);
    release_out();
    chk("clean_frame_cnt", 64'(frame_cnt), 64'd4);

    // Backpressure: result held, input ignored
    feed(seq18, 8, 1'b0, cyc);
    wait_out("bp_valid");
    in_valid = 1'b1;
    in_data  = 5'd9;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_sum",   64'(out_sum),   64'h24);
      chk("bp_in_ready",   64'(in_ready),  64'd0);
    end
    chk("bp_lanes",     64'(lane_out),  64'(lanes18));
    chk("bp_frame_cnt", 64'(frame_cnt), 64'd4);
    in_valid = 1'b0;
    release_out();
    chk("bp_release_cnt",   64'(frame_cnt), 64'd5);
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    step();
    chk("bp_single_inc",    64'(frame_cnt), 64'd5);

    // Reset mid-fill discards the partial frame
    feed(seq18, 5, 1'b0, cyc);
    rst = 1'b1;
    #2;
    chk("mid_rst_lanes",  64'(lane_out),   64'd0);
    chk("mid_rst_cnt",    64'(frame_cnt),  64'd0);
    chk("mid_rst_sticky", 64'(err_sticky), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    feed(all2, 8, 1'b0, cyc);
    wait_out("mid_valid");
    chk("mid_sum",   64'(out_sum),  64'h10);
    chk("mid_err",   64'(out_err),  64'd0);
    chk("mid_lanes", 64'(lane_out), 64'(all2));
    release_out();
    chk("mid_frame_cnt", 64'(frame_cnt), 64'd1);

    // in_valid toggling: eight accepts over fifteen cycles
    feed(seq18, 8, 1'b1, cyc);
    chk("gap_cycles",   64'(cyc),      64'd15);
    chk("gap_in_ready", 64'(in_ready), 64'd0);
    wait_out("gap_valid");
    chk("gap_lanes", 64'(lane_out), 64'(lanes18));
    chk("gap_sum",   64'(out_sum),  64'h24);
    chk("gap_err",   64'(out_err),  64'd0);
    release_out();
    chk("gap_frame_cnt", 64'(frame_cnt), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_tree_driver.md
ADDER_TREE_DRIVER -- requirements
Module: adder_tree_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 5, operand width per lane.
REQ-002 SHALL have parameter SUM_W, default WIDTH+3, width of the tree result it receives and checks.
REQ-003 SHALL have parameter LAT, default 2, tree latency in clk cycles from lane change to valid tree_sum.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  serial operand valid.
REQ-007 SHALL have port in_ready  output  1  driver accepts operand.
REQ-008 SHALL have port in_data  input  WIDTH  serial operand.
REQ-009 SHALL have port lane_out  output  8*WIDTH  eight tree operands, lane k at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port tree_sum  input  SUM_W  result returned by the adder tree.
REQ-011 SHALL have port out_valid  output  1  frame result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_sum  output  SUM_W  captured tree_sum.
REQ-014 SHALL have port out_err  output  1  captured tree_sum differs from internal reference sum.
REQ-015 SHALL have port err_sticky  output  1  set on any out_err, cleared only by rst.
REQ-016 SHALL have port frame_cnt  output  16  completed frames, wraps 0xFFFF -> 0x0000.

Function
REQ-017 SHALL implement states FILL, WAIT, HOLD; reset state FILL.
REQ-018 SHALL drive in_ready=1 only in FILL; accept occurs on edge where in_valid && in_ready.
REQ-019 SHALL write accepted word n (n=0..7, fill counter) into lane n; other lanes unchanged.
REQ-020 SHALL accumulate accepted words into a SUM_W-bit reference acc, cleared to 0 at start of each frame (on first accept, acc = in_data).
REQ-021 SHALL on 8th accept (edge E0) enter WAIT with wait_cnt=LAT; lane_out SHALL stay constant from E0 until next frame's first accept.
REQ-022 SHALL in WAIT decrement wait_cnt each cycle; on edge with wait_cnt==0 (E0+LAT+1) capture out_sum=tree_sum, out_err=(tree_sum!=acc), enter HOLD.
REQ-023 SHALL in HOLD assert out_valid; out_sum/out_err stable until handshake out_valid && out_ready.
REQ-024 SHALL on output handshake: increment frame_cnt, deassert out_valid, return to FILL with fill counter 0.
REQ-025 SHALL NOT accept input while in WAIT or HOLD, regardless of in_valid.
REQ-026 SHALL set err_sticky on the capture edge when mismatch is detected.
REQ-027 SHALL tolerate in_valid gaps in FILL without altering lanes, acc or counter.
REQ-028 SHALL perform acc addition modulo 2^SUM_W; with defaults no overflow (max 8*31=248 < 256).

Reset
REQ-029 SHALL on rst, at any time incl. mid-frame, force: state FILL, fill counter 0, wait_cnt 0, acc 0, lane_out 0, out_valid 0, out_sum 0, out_err 0, err_sticky 0, frame_cnt 0, in_ready 1 after release.
REQ-030 SHALL discard a partially filled or in-flight frame on reset; no output produced for it.

Verification
REQ-031 SHALL verify basic frame: words 1..8, model tree (LAT=2) -> lane_out 8,7,...,1 (lane7..0), out_sum=0x24, out_err=0, frame_cnt=1, capture exactly E0+3.
REQ-032 SHALL verify max operands: eight 0x1F -> out_sum=0xF8, out_err=0.
REQ-033 SHALL verify mismatch: words 1..8, tree model returns 0x25 -> out_err=1, err_sticky=1, remains 1 after next correct frame.
REQ-034 SHALL verify backpressure: out_ready low 10 cycles -> out_valid and out_sum held, in_ready=0 throughout, in_valid ignored; one frame_cnt increment on release.
REQ-035 SHALL verify reset mid-fill after 5 words, then words 2,2,2,2,2,2,2,2 -> first output out_sum=0x10, frame_cnt=1.
REQ-036 SHALL verify in_valid toggling every other cycle -> same results as REQ-031, 8 accepts over 15 cycles.
